// File: rtl/dot_vec_serializer_pkg.sv
// Shared defaults, derived sizes and types for the dot-product vector serializer.
package dot_pkg;
  localparam int DATA_W    = 8;
  localparam int N         = 3;
  localparam int FRAME_LEN = 2 * N;
  localparam int IDX_W     = $clog2(FRAME_LEN);
  localparam int RES_W     = 2 * DATA_W + $clog2(N);

  typedef logic [DATA_W-1:0] elem_t;
  typedef elem_t [N-1:0]     vec_t;

  typedef enum logic {IDLE, SEND} state_t;
endpackage

// File: rtl/dot_vec_serializer_buf.sv
// Two-entry frame store (active + pending) for the serializer; exposes next-cycle active data.
module dot_vec_buf #(
  parameter int DATA_W = dot_pkg::DATA_W,
  parameter int N      = dot_pkg::N
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  input  logic [N*DATA_W-1:0] in_a,
  input  logic [N*DATA_W-1:0] in_b,
  output logic                in_ready,
  input  logic                advance,
  output logic                pend_valid,
  output logic [N*DATA_W-1:0] nxt_a,
  output logic [N*DATA_W-1:0] nxt_b
);
  import dot_pkg::*;

  logic [N*DATA_W-1:0] act_a, act_b, pend_a, pend_b;
  logic                accept;

  assign in_ready = !reset && !pend_valid;
  assign accept   = in_valid && in_ready;

  // When the active frame is released, pending has priority over a same-cycle arrival.
  always_comb begin
    nxt_a = act_a;
    nxt_b = act_b;
    if (advance) begin
      if (pend_valid) begin
        nxt_a = pend_a;
        nxt_b = pend_b;
      end else if (accept) begin
        nxt_a = in_a;
        nxt_b = in_b;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_valid <= 1'b0;
    end else if (advance && pend_valid) begin
      pend_valid <= 1'b0;
    end else if (!advance && accept) begin
      pend_valid <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    act_a <= nxt_a;
    act_b <= nxt_b;
    if (!advance && accept) begin
      pend_a <= in_a;
      pend_b <= in_b;
    end
  end
endmodule

// File: rtl/dot_vec_serializer.sv
// Serializes (a, b) vector pairs as a[0..N-1], b[0..N-1] with sof/eof markers.
// Optional macro DOT_REF_EN adds the registered reference dot product output ref_dot.
module dot_vec_serializer #(
  parameter int DATA_W = dot_pkg::DATA_W,
  parameter int N      = dot_pkg::N
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [N*DATA_W-1:0] in_a,
  input  logic [N*DATA_W-1:0] in_b,
  output logic [DATA_W-1:0]   dout,
  output logic                dout_valid,
  output logic                sof,
  output logic                eof
`ifdef DOT_REF_EN
  ,
  output logic [2*DATA_W+$clog2(N)-1:0] ref_dot
`endif
);
  import dot_pkg::*;

  localparam int FRAME_LEN = 2 * N;
  localparam int IDX_W     = $clog2(FRAME_LEN);

  state_t              state, state_nxt;
  logic [IDX_W-1:0]    idx, idx_nxt;
  logic                last, advance, accept, pend_valid;
  logic [N*DATA_W-1:0] nxt_a, nxt_b;
  logic [DATA_W-1:0]   dout_nxt;
  logic                dout_valid_nxt, sof_nxt, eof_nxt;

  assign last    = (state == SEND) && (idx == IDX_W'(FRAME_LEN - 1));
  assign advance = (state == IDLE) || last;
  assign accept  = in_valid && in_ready;

  dot_vec_buf #(.DATA_W(DATA_W), .N(N)) u_buf (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_ready   (in_ready),
    .advance    (advance),
    .pend_valid (pend_valid),
    .nxt_a      (nxt_a),
    .nxt_b      (nxt_b)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    case (state)
      IDLE: begin
        idx_nxt = '0;
        if (accept) state_nxt = SEND;
      end
      SEND: begin
        if (last) begin
          idx_nxt = '0;
          if (!(pend_valid || accept)) state_nxt = IDLE;
        end else begin
          idx_nxt = idx + 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        idx_nxt   = '0;
      end
    endcase
  end

  // Outputs are computed from next-cycle state so that every port comes straight off a flop.
  always_comb begin
    int k;
    k              = int'(idx_nxt);
    dout_nxt       = '0;
    dout_valid_nxt = 1'b0;
    sof_nxt        = 1'b0;
    eof_nxt        = 1'b0;
    if (state_nxt == SEND) begin
      dout_valid_nxt = 1'b1;
      sof_nxt        = (k == 0);
      eof_nxt        = (k == FRAME_LEN - 1);
      if (k < N) dout_nxt = nxt_a[k*DATA_W +: DATA_W];
      else       dout_nxt = nxt_b[(k-N)*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dout       <= '0;
      dout_valid <= 1'b0;
      sof        <= 1'b0;
      eof        <= 1'b0;
    end else begin
      dout       <= dout_nxt;
      dout_valid <= dout_valid_nxt;
      sof        <= sof_nxt;
      eof        <= eof_nxt;
    end
  end

`ifdef DOT_REF_EN
  localparam int RES_W = 2 * DATA_W + $clog2(N);

  function automatic logic [RES_W-1:0] dot_sum(input logic [N*DATA_W-1:0] a,
                                                input logic [N*DATA_W-1:0] b);
    logic [RES_W-1:0] acc;
    acc = '0;
    for (int i = 0; i < N; i++) begin
      acc = acc + RES_W'(a[i*DATA_W +: DATA_W]) * RES_W'(b[i*DATA_W +: DATA_W]);
    end
    return acc;
  endfunction

  // Loaded together with eof so the result appears on the frame's last beat.
  always_ff @(posedge clk) begin
    if (reset) ref_dot <= '0;
    else if (eof_nxt) ref_dot <= dot_sum(nxt_a, nxt_b);
  end
`endif
endmodule

// File: tb/tb_dot_vec_serializer.sv
// Bench for dot_vec_serializer: frame-schedule reference model plus directed literal cases.
module tb_dot_vec_serializer;
  localparam int DW  = 8;
  localparam int NN  = 3;
  localparam int FL  = 2 * NN;
  localparam int RW  = 2 * DW + $clog2(NN);
  localparam int PER = 10;

  typedef logic [NN*DW-1:0] vflat_t;

  logic          clk = 1'b0;
  logic          reset, in_valid, in_ready, dout_valid, sof, eof;
  vflat_t        in_a, in_b;
  logic [DW-1:0] dout;
`ifdef DOT_REF_EN
  logic [RW-1:0] ref_dot;
`endif

  always #(PER/2) clk = ~clk;

  dot_vec_serializer #(.DATA_W(DW), .N(NN)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .dout       (dout),
    .dout_valid (dout_valid),
    .sof        (sof),
    .eof        (eof)
`ifdef DOT_REF_EN
    ,
    .ref_dot    (ref_dot)
`endif
  );

  typedef struct {
    int     acc;
    int     start;
    int     fin;
    vflat_t a;
    vflat_t b;
    int     dot;
  } frame_t;

  frame_t frames[$];
  int     cyc      = 0;
  int     last_end = -1;
  int     exp_ref  = 0;
  bit     armed    = 1'b0;
  int     errors   = 0;
  int     checks   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic vflat_t pack3(input int x0, input int x1, input int x2);
    vflat_t r;
    r[0*DW +: DW] = DW'(x0);
    r[1*DW +: DW] = DW'(x1);
    r[2*DW +: DW] = DW'(x2);
    return r;
  endfunction

  function automatic int dot_of(input vflat_t a, input vflat_t b);
    int s = 0;
    for (int i = 0; i < NN; i++) s += int'(a[i*DW +: DW]) * int'(b[i*DW +: DW]);
    return s;
  endfunction

  // Two frames may be held at once: the one on the wire and one waiting.
  function automatic bit model_ready();
    int cnt = 0;
    foreach (frames[i]) if (frames[i].acc <= cyc && frames[i].fin >= cyc) cnt++;
    return !reset && (cnt < 2);
  endfunction

  // Reference schedule: a frame starts one cycle after acceptance or right after the previous one.
  initial begin : model
    bit     take;
    frame_t f;
    forever begin
      @(posedge clk);
      if (reset) begin
        frames.delete();
        exp_ref  = 0;
        last_end = -1;
        armed    = 1'b1;
        cyc++;
      end else begin
        take = in_valid && model_ready();
        cyc++;
        if (take) begin
          f.acc   = cyc;
          f.start = (cyc > last_end + 1) ? cyc : last_end + 1;
          f.fin   = f.start + FL - 1;
          f.a     = in_a;
          f.b     = in_b;
          f.dot   = dot_of(in_a, in_b);
          frames.push_back(f);
          last_end = f.fin;
        end
        while (frames.size() > 0 && frames[0].fin < cyc) void'(frames.pop_front());
        foreach (frames[i]) if (frames[i].fin == cyc) exp_ref = frames[i].dot;
      end
    end
  end

  initial begin : compare
    logic          v, s, e;
    logic [DW-1:0] d;
    int            k;
    forever begin
      @(negedge clk);
      if (armed) begin
        v = 1'b0; s = 1'b0; e = 1'b0; d = '0;
        foreach (frames[i]) begin
          if (frames[i].start <= cyc && cyc <= frames[i].fin) begin
            k = cyc - frames[i].start;
            v = 1'b1;
            s = (k == 0);
            e = (k == FL - 1);
            d = (k < NN) ? frames[i].a[k*DW +: DW] : frames[i].b[(k-NN)*DW +: DW];
          end
        end
        chk("m_dout_valid", 32'(dout_valid), 32'(v));
        chk("m_dout", 32'(dout), 32'(d));
        chk("m_sof", 32'(sof), 32'(s));
        chk("m_eof", 32'(eof), 32'(e));
        chk("m_in_ready", 32'(in_ready), 32'(model_ready()));
`ifdef DOT_REF_EN
        chk("m_ref_dot", 32'(ref_dot), 32'(exp_ref));
`endif
      end
    end
  end

  initial begin : watchdog
    #(PER * 20000);
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic offer(input vflat_t a, input vflat_t b, output time t_acc);
    bit r, done;
    done   = 1'b0;
    t_acc  = 0;
    in_a   = a;
    in_b   = b;
    in_valid = 1'b1;
    for (int n = 0; n < 64 && !done; n++) begin
      @(negedge clk);
      r = in_ready;
      @(posedge clk);
      if (r) begin
        done  = 1'b1;
        t_acc = $time;
      end
    end
    if (!done) chk("offer_timeout", 32'(0), 32'(1));
    #1;
  endtask

  initial begin : stim
    int  lit[12];
    time t1, t2, t3;
    reset = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_dout_valid", 32'(dout_valid), 32'(0));
    chk("rst_dout", 32'(dout), 32'(0));
    chk("rst_in_ready", 32'(in_ready), 32'(1));
    @(posedge clk); #1;

    // Single frame
    lit = '{1, 2, 3, 4, 5, 6, 0, 0, 0, 0, 0, 0};
    in_a = pack3(1, 2, 3); in_b = pack3(4, 5, 6); in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    for (int k = 0; k < FL; k++) begin
      @(negedge clk);
      chk("t1_dout", 32'(dout), 32'(lit[k]));
      chk("t1_sof", 32'(sof), 32'(k == 0));
      chk("t1_eof", 32'(eof), 32'(k == FL - 1));
`ifdef DOT_REF_EN
      if (k == FL - 1) chk("t1_ref_dot", 32'(ref_dot), 32'(32));
`endif
    end
    @(negedge clk);
    chk("t1_idle_after", 32'(dout_valid), 32'(0));
    @(posedge clk); #1;

    // Back-to-back pairs
    in_a = pack3(1, 2, 3); in_b = pack3(4, 5, 6); in_valid = 1'b1;
    @(posedge clk); #1;
    in_a = pack3(7, 8, 9); in_b = pack3(10, 11, 12);
    for (int k = 0; k < 2 * FL; k++) begin
      @(negedge clk);
      chk("t2_valid", 32'(dout_valid), 32'(1));
      chk("t2_dout", 32'(dout), 32'(k + 1));
      chk("t2_sof", 32'(sof), 32'(k == 0 || k == 6));
`ifdef DOT_REF_EN
      if (k == 5)  chk("t2_ref_p1", 32'(ref_dot), 32'(32));
      if (k == 11) chk("t2_ref_p2", 32'(ref_dot), 32'(266));
`endif
      if (k == 0) begin
        @(posedge clk); #1 in_valid = 1'b0;
      end
    end
    repeat (2) @(posedge clk); #1;

    // Backpressure with valid held high
    offer(pack3(20, 21, 22), pack3(23, 24, 25), t1);
    offer(pack3(30, 31, 32), pack3(33, 34, 35), t2);
    offer(pack3(40, 41, 42), pack3(43, 44, 45), t3);
    in_valid = 1'b0;
    chk("bp_second_gap", 32'((t2 - t1) / PER), 32'(1));
    chk("bp_third_gap", 32'((t3 - t1) / PER), 32'(7));
    repeat (25) @(posedge clk); #1;

    // All-ones
    in_a = pack3(255, 255, 255); in_b = pack3(255, 255, 255); in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    for (int k = 0; k < FL; k++) begin
      @(negedge clk);
      chk("t4_dout", 32'(dout), 32'(255));
`ifdef DOT_REF_EN
      if (k == FL - 1) chk("t4_ref_dot", 32'(ref_dot), 32'(195075));
`endif
    end
    @(posedge clk); #1;

    // Reset at beat 3 with pending full
    in_a = pack3(5, 6, 7); in_b = pack3(8, 9, 10); in_valid = 1'b1;
    @(posedge clk); #1;
    in_a = pack3(11, 12, 13); in_b = pack3(14, 15, 16);
    @(posedge clk); #1 in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    chk("t5_beat3", 32'(dout), 32'(8));
    chk("t5_ready_in_reset", 32'(in_ready), 32'(0));
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("t5_dout_valid", 32'(dout_valid), 32'(0));
    chk("t5_dout", 32'(dout), 32'(0));
    chk("t5_sof", 32'(sof), 32'(0));
    chk("t5_eof", 32'(eof), 32'(0));
    chk("t5_in_ready", 32'(in_ready), 32'(1));
`ifdef DOT_REF_EN
    chk("t5_ref_dot", 32'(ref_dot), 32'(0));
`endif
    @(posedge clk); #1;
    lit = '{9, 8, 7, 1, 2, 3, 0, 0, 0, 0, 0, 0};
    in_a = pack3(9, 8, 7); in_b = pack3(1, 2, 3); in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    for (int k = 0; k < FL; k++) begin
      @(negedge clk);
      chk("t5_after_dout", 32'(dout), 32'(lit[k]));
      chk("t5_after_sof", 32'(sof), 32'(k == 0));
`ifdef DOT_REF_EN
      if (k == FL - 1) chk("t5_after_ref", 32'(ref_dot), 32'(46));
`endif
    end
    @(posedge clk); #1;

    // Accept on the last beat with pending empty
    in_a = pack3(1, 2, 3); in_b = pack3(4, 5, 6); in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (FL - 1) @(posedge clk);
    #1;
    in_a = pack3(50, 51, 52); in_b = pack3(53, 54, 55); in_valid = 1'b1;
    @(negedge clk);
    chk("t6_eof", 32'(eof), 32'(1));
    chk("t6_ready_last", 32'(in_ready), 32'(1));
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    chk("t6_valid_gapless", 32'(dout_valid), 32'(1));
    chk("t6_sof_gapless", 32'(sof), 32'(1));
    chk("t6_dout_first", 32'(dout), 32'(50));
    repeat (8) @(posedge clk); #1;

    // Randomized traffic with occasional resets
    for (int n = 0; n < 600; n++) begin
      reset    = ($urandom_range(0, 99) < 2);
      in_valid = ($urandom_range(0, 99) < 55);
      in_a     = ($urandom_range(0, 9) == 0) ? '1 : vflat_t'($urandom);
      in_b     = ($urandom_range(0, 9) == 0) ? '1 : vflat_t'($urandom);
      @(posedge clk); #1;
    end
    reset = 1'b0; in_valid = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
